mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 p0_req, p0_lock, p0_we  input  1 each  CPU data port: request, lock hold, write enable.
REQ-004 p0_addr  input  8; p0_wdata  input  16  CPU data port address and write data.
REQ-005 p0_gnt  output  1; p0_rvalid  output  1  CPU data port grant and read-data-valid.
REQ-006 p1_req, p1_lock, p1_we  input  1; p1_addr  input  8; p1_wdata  input  16  host/loader port, same meaning as port 0.
REQ-007 p1_gnt  output  1; p1_rvalid  output  1  host port grant and read-data-valid.
REQ-008 rdata  output  16  shared read data; equals mem_dataout.
REQ-009 mem_addr  output  8; mem_we  output  1; mem_datain  output  16  to the shared memory (256 x 16).
REQ-010 mem_dataout  input  16  from the shared memory; valid one cycle after the address is presented.

Function
REQ-011 At most one of p0_gnt/p1_gnt SHALL be high in any cycle.
REQ-012 Grant SHALL be combinational in the request cycle; the granted port's addr/we/wdata SHALL drive mem_addr/mem_we/mem_datain in that cycle.
REQ-013 With no grant: mem_we=0, mem_addr=0, mem_datain=0.
REQ-014 Requester SHALL hold req, addr, we and wdata stable until it sees gnt; each gnt = exactly one access.
REQ-015 Granted read (we=0) SHALL set that port's rvalid for exactly the next cycle; rdata valid in that cycle.
REQ-016 Granted write SHALL set no rvalid.
REQ-017 FSM states: ARB, LOCK0, LOCK1.
REQ-018 ARB: single requester wins; both requesting -> port not served last wins (round-robin pointer); winner becomes last-served.
REQ-019 ARB: grant with that port's lock=1 -> next state LOCKn; otherwise stay ARB.
REQ-020 LOCKn, port n req=1: port n granted regardless of other port; lock=1 -> stay LOCKn, lock=0 -> ARB.
REQ-021 LOCKn, port n req=0: lock released; REQ-018/019 arbitration applies that same cycle.
REQ-022 Back-to-back grants to the same or alternating ports SHALL be allowed every cycle; no idle cycle inserted.

Reset
REQ-023 While rst=1: p0_gnt=p1_gnt=0, mem_we=0, mem_addr=0, mem_datain=0, p0_rvalid=p1_rvalid=0.
REQ-024 Reset SHALL set state=ARB, last-served=port 1 (port 0 wins first tie), lock counter=0.
REQ-025 Reset during a read SHALL suppress the pending rvalid in the following cycle.

Configuration
REQ-026 Macro MEM_ARB_TIMEOUT_EN defined: 3-bit counter counts consecutive locked grants to the owner; on the 8th such grant, if the other port is requesting, next state SHALL be ARB with last-served = owner, so the other port wins the next cycle; counter clears on any return to ARB.
REQ-027 MEM_ARB_TIMEOUT_EN undefined: no counter; lock duration unlimited.

Verification
REQ-028 Reset release, p0 read addr 0x10, p1 idle -> p0_gnt same cycle, mem_addr=0x10, next cycle p0_rvalid=1, rdata=mem[0x10].
REQ-029 p0 and p1 both request continuously, no lock -> grants alternate p0,p1,p0,p1 starting with p0.
REQ-030 p1 writes 0xBEEF to 0x20 with lock=1 for 3 beats, then lock=0 while p0 requests -> p1 granted 4 consecutive cycles, p0 granted 5th; mem_we=1 on p1 beats only.
REQ-031 rst asserted in cycle after p0 read grant -> p0_rvalid stays 0; state ARB after release.
REQ-032 MEM_ARB_TIMEOUT_EN defined, p0 holds lock=1 and req=1 indefinitely, p1 requesting -> p0 granted 8 cycles, p1 granted 9th; undefined -> p1 never granted while p0 locks.
REQ-033 Every cycle of random traffic -> never two grants, rvalid only after read grants, memory model contents match write order.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - bus bundle between two requesters, the arbiter and a 256x16 memory
//
// Signals
//   p0_*/p1_*   : requester ports (req, lock, we, addr[7:0], wdata[15:0] in; gnt, rvalid out)
//   rdata       : shared read data returned to the requesters
//   mem_*       : shared single-port memory (addr[7:0], we, datain[15:0] out; dataout[15:0] in)
// Modports
//   slave  : arbiter side
//   master : requesters plus memory side
interface mem_arbiter_if;
    logic        p0_req;
    logic        p0_lock;
    logic        p0_we;
    logic [7:0]  p0_addr;
    logic [15:0] p0_wdata;
    logic        p0_gnt;
    logic        p0_rvalid;

    logic        p1_req;
    logic        p1_lock;
    logic        p1_we;
    logic [7:0]  p1_addr;
    logic [15:0] p1_wdata;
    logic        p1_gnt;
    logic        p1_rvalid;

    logic [15:0] rdata;

    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [15:0] mem_datain;
    logic [15:0] mem_dataout;

    modport slave (
        input  p0_req, p0_lock, p0_we, p0_addr, p0_wdata,
        output p0_gnt, p0_rvalid,
        input  p1_req, p1_lock, p1_we, p1_addr, p1_wdata,
        output p1_gnt, p1_rvalid,
        output rdata,
        output mem_addr, mem_we, mem_datain,
        input  mem_dataout
    );

    modport master (
        output p0_req, p0_lock, p0_we, p0_addr, p0_wdata,
        input  p0_gnt, p0_rvalid,
        output p1_req, p1_lock, p1_we, p1_addr, p1_wdata,
        input  p1_gnt, p1_rvalid,
        input  rdata,
        input  mem_addr, mem_we, mem_datain,
        output mem_dataout
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter with lock for a shared 256x16 memory
//
// Ports
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : mem_arbiter_if.slave (requester ports, shared rdata, memory side)
// Behaviour
//   Grant is combinational in the request cycle and the granted port drives the memory.
//   A read grant raises that port's rvalid for the next cycle, when mem_dataout is valid.
//   A granted port with lock=1 keeps the memory until it drops lock or stops requesting.
// Build option
//   MEM_ARB_TIMEOUT_EN : bound a lock to 8 consecutive grants when the other port waits.
module mem_arbiter (
    input  logic            clk,
    input  logic            rst,
    mem_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   last;          // 1: port 1 was served last, so port 0 wins a tie
    logic   last_next;
    logic   do_arb;
    logic   gnt0;
    logic   gnt1;
    logic   rv0_q;
    logic   rv1_q;

`ifdef MEM_ARB_TIMEOUT_EN
    // Number of consecutive grants to the lock owner, saturating at 7 so that
    // every grant from the 8th onward can hand over as soon as the other port asks.
    logic [2:0] cnt;
    logic [2:0] cnt_next;
`endif

    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        state_next = state;
        last_next  = last;
        do_arb     = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_next   = cnt;
`endif

        case (state)
            LOCK0: begin
                if (bus.p0_req) begin
                    gnt0      = 1'b1;
                    last_next = 1'b0;
                    if (!bus.p0_lock) begin
                        state_next = ARB;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (cnt == 3'd7 && bus.p1_req) begin
                        state_next = ARB;
                    end
`endif
                end else begin
                    do_arb = 1'b1;
                end
            end
            LOCK1: begin
                if (bus.p1_req) begin
                    gnt1      = 1'b1;
                    last_next = 1'b1;
                    if (!bus.p1_lock) begin
                        state_next = ARB;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (cnt == 3'd7 && bus.p0_req) begin
                        state_next = ARB;
                    end
`endif
                end else begin
                    do_arb = 1'b1;
                end
            end
            default: begin
                do_arb = 1'b1;
            end
        endcase

        // Owner gone (or no owner): plain round-robin in this same cycle.
        if (do_arb) begin
            state_next = ARB;
            if (bus.p0_req && (last || !bus.p1_req)) begin
                gnt0      = 1'b1;
                last_next = 1'b0;
                if (bus.p0_lock) begin
                    state_next = LOCK0;
                end
            end else if (bus.p1_req) begin
                gnt1      = 1'b1;
                last_next = 1'b1;
                if (bus.p1_lock) begin
                    state_next = LOCK1;
                end
            end
        end

`ifdef MEM_ARB_TIMEOUT_EN
        if (state_next == ARB) begin
            cnt_next = 3'd0;
        end else if (do_arb) begin
            cnt_next = 3'd1;
        end else if (cnt != 3'd7) begin
            cnt_next = cnt + 3'd1;
        end
`endif

        if (rst) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    always_comb begin
        bus.mem_addr   = 8'd0;
        bus.mem_we     = 1'b0;
        bus.mem_datain = 16'd0;
        if (gnt0) begin
            bus.mem_addr   = bus.p0_addr;
            bus.mem_we     = bus.p0_we;
            bus.mem_datain = bus.p0_wdata;
        end else if (gnt1) begin
            bus.mem_addr   = bus.p1_addr;
            bus.mem_we     = bus.p1_we;
            bus.mem_datain = bus.p1_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB;
            last  <= 1'b1;
            rv0_q <= 1'b0;
            rv1_q <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt   <= 3'd0;
`endif
        end else begin
            state <= state_next;
            last  <= last_next;
            rv0_q <= gnt0 & ~bus.p0_we;
            rv1_q <= gnt1 & ~bus.p1_we;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt   <= cnt_next;
`endif
        end
    end

    assign bus.p0_gnt    = gnt0;
    assign bus.p1_gnt    = gnt1;
    // Gating with rst drops an rvalid whose read was cut short by reset.
    assign bus.p0_rvalid = rv0_q & ~rst;
    assign bus.p1_rvalid = rv1_q & ~rst;
    assign bus.rdata     = bus.mem_dataout;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam bit TO = 1'b1;
`else
    localparam bit TO = 1'b0;
`endif

    // Shared memory: registered read, one cycle latency.
    logic [15:0] sram [256];
    always @(posedge clk) begin
        if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_datain;
        bus.mem_dataout <= sram[bus.mem_addr];
    end

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic [1:0]  lock;
        logic [1:0]  we;
        logic [7:0]  a0;
        logic [7:0]  a1;
        logic [15:0] d0;
        logic [15:0] d1;
    } vin_t;

    typedef struct {
        vin_t in;
        logic g0;
        logic g1;
        logic rv0;
        logic rv1;
    } row_t;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: owner of the lock (-1 none), last served port,
    // length of the current run of grants to the owner, pending read.
    int          m_owner;
    int          m_last;
    int          m_streak;
    bit          m_pend;
    int          m_pend_port;
    logic [7:0]  m_pend_addr;
    logic [15:0] ref_mem [256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input vin_t v, output int g);
        logic        rv0e;
        logic        rv1e;
        logic [7:0]  ea;
        logic [15:0] ed;
        logic        ewe;
        int          other;
        @(negedge clk);
        rst          = v.rst;
        bus.p0_req   = v.req[0];
        bus.p0_lock  = v.lock[0];
        bus.p0_we    = v.we[0];
        bus.p0_addr  = v.a0;
        bus.p0_wdata = v.d0;
        bus.p1_req   = v.req[1];
        bus.p1_lock  = v.lock[1];
        bus.p1_we    = v.we[1];
        bus.p1_addr  = v.a1;
        bus.p1_wdata = v.d1;
        #1;
        g = -1;
        if (!v.rst) begin
            if (m_owner >= 0 && v.req[m_owner]) g = m_owner;
            else if (v.req == 2'b11) g = 1 - m_last;
            else if (v.req[0]) g = 0;
            else if (v.req[1]) g = 1;
        end
        ea   = (g == 0) ? v.a0 : (g == 1) ? v.a1 : 8'd0;
        ed   = (g == 0) ? v.d0 : (g == 1) ? v.d1 : 16'd0;
        ewe  = (g >= 0) ? v.we[g] : 1'b0;
        rv0e = !v.rst && m_pend && m_pend_port == 0;
        rv1e = !v.rst && m_pend && m_pend_port == 1;

        chk("p0_gnt", bus.p0_gnt, g == 0);
        chk("p1_gnt", bus.p1_gnt, g == 1);
        chk("two_gnts", bus.p0_gnt & bus.p1_gnt, 0);
        chk("mem_addr", bus.mem_addr, ea);
        chk("mem_we", bus.mem_we, ewe);
        chk("mem_datain", bus.mem_datain, ed);
        chk("p0_rvalid", bus.p0_rvalid, rv0e);
        chk("p1_rvalid", bus.p1_rvalid, rv1e);
        if (rv0e || rv1e) chk("rdata", bus.rdata, ref_mem[m_pend_addr]);

        if (v.rst) begin
            m_owner  = -1;
            m_last   = 1;
            m_streak = 0;
            m_pend   = 0;
        end else if (g >= 0) begin
            other       = 1 - g;
            m_pend      = !v.we[g];
            m_pend_port = g;
            m_pend_addr = ea;
            m_streak    = (m_owner == g) ? m_streak + 1 : 1;
            m_last      = g;
            if (v.we[g]) ref_mem[ea] = ed;
            if (!v.lock[g]) m_owner = -1;
            else if (TO && m_streak >= 8 && v.req[other]) m_owner = -1;
            else m_owner = g;
        end else begin
            m_pend  = 0;
            m_owner = -1;
        end
    endtask

    function automatic row_t mk(input logic r, input logic [1:0] req, input logic [1:0] lock,
                                input logic [1:0] we, input logic [7:0] a0, input logic [7:0] a1,
                                input logic [15:0] d0, input logic [15:0] d1,
                                input logic g0, input logic g1, input logic rv0, input logic rv1);
        row_t t;
        t.in.rst  = r;
        t.in.req  = req;
        t.in.lock = lock;
        t.in.we   = we;
        t.in.a0   = a0;
        t.in.a1   = a1;
        t.in.d0   = d0;
        t.in.d1   = d1;
        t.g0      = g0;
        t.g1      = g1;
        t.rv0     = rv0;
        t.rv1     = rv1;
        return t;
    endfunction

    row_t rows[$];
    vin_t cur;
    logic [1:0] hold;
    int g;

    initial begin
        for (int i = 0; i < 256; i++) begin
            sram[i]    = 16'(i * 257) ^ 16'h5A5A;
            ref_mem[i] = 16'(i * 257) ^ 16'h5A5A;
        end
        m_owner = -1; m_last = 1; m_streak = 0; m_pend = 0; m_pend_port = 0; m_pend_addr = 8'd0;
        rst = 1'b1;
        bus.p0_req = 0; bus.p0_lock = 0; bus.p0_we = 0; bus.p0_addr = 0; bus.p0_wdata = 0;
        bus.p1_req = 0; bus.p1_lock = 0; bus.p1_we = 0; bus.p1_addr = 0; bus.p1_wdata = 0;

        // Reset, then p0 reads 0x10.
        rows.push_back(mk(1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0, 0, 0, 0, 0));
        rows.push_back(mk(0, 2'b01, 2'b00, 2'b00, 8'h10, 8'h00, 16'h0, 16'h0, 1, 0, 0, 0));
        rows.push_back(mk(0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0, 0, 0, 1, 0));
        // Both request without lock: alternate starting with p0.
        rows.push_back(mk(1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0, 0, 0, 0, 0));
        rows.push_back(mk(0, 2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 16'h0, 16'h0, 1, 0, 0, 0));
        rows.push_back(mk(0, 2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 16'h0, 16'h0, 0, 1, 1, 0));
        rows.push_back(mk(0, 2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 16'h0, 16'h0, 1, 0, 0, 1));
        rows.push_back(mk(0, 2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 16'h0, 16'h0, 0, 1, 1, 0));
        // p1 locked writes of 0xBEEF to 0x20, p0 waits, then reads back.
        rows.push_back(mk(1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0, 0, 0, 0, 0));
        rows.push_back(mk(0, 2'b10, 2'b10, 2'b10, 8'h00, 8'h20, 16'h0, 16'hBEEF, 0, 1, 0, 0));
        rows.push_back(mk(0, 2'b11, 2'b10, 2'b10, 8'h30, 8'h20, 16'h0, 16'hBEEF, 0, 1, 0, 0));
        rows.push_back(mk(0, 2'b11, 2'b10, 2'b10, 8'h30, 8'h20, 16'h0, 16'hBEEF, 0, 1, 0, 0));
        rows.push_back(mk(0, 2'b11, 2'b00, 2'b10, 8'h30, 8'h20, 16'h0, 16'hBEEF, 0, 1, 0, 0));
        rows.push_back(mk(0, 2'b01, 2'b00, 2'b00, 8'h30, 8'h00, 16'h0, 16'h0, 1, 0, 0, 0));
        rows.push_back(mk(0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0, 0, 0, 1, 0));
        rows.push_back(mk(0, 2'b01, 2'b00, 2'b00, 8'h20, 8'h00, 16'h0, 16'h0, 1, 0, 0, 0));
        rows.push_back(mk(0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0, 0, 0, 1, 0));
        // Reset right after a read grant suppresses rvalid; arbitration restarts.
        rows.push_back(mk(1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0, 0, 0, 0, 0));
        rows.push_back(mk(0, 2'b01, 2'b00, 2'b00, 8'h10, 8'h00, 16'h0, 16'h0, 1, 0, 0, 0));
        rows.push_back(mk(1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0, 0, 0, 0, 0));
        rows.push_back(mk(0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0, 0, 0, 0, 0));
        rows.push_back(mk(0, 2'b11, 2'b00, 2'b00, 8'h05, 8'h06, 16'h0, 16'h0, 1, 0, 0, 0));

        foreach (rows[i]) begin
            cycle(rows[i].in, g);
            chk($sformatf("tbl%0d_p0_gnt", i), bus.p0_gnt, rows[i].g0);
            chk($sformatf("tbl%0d_p1_gnt", i), bus.p1_gnt, rows[i].g1);
            chk($sformatf("tbl%0d_p0_rvalid", i), bus.p0_rvalid, rows[i].rv0);
            chk($sformatf("tbl%0d_p1_rvalid", i), bus.p1_rvalid, rows[i].rv1);
        end

        // p0 holds lock while p1 keeps requesting.
        cur = '{rst: 1'b1, req: 2'b00, lock: 2'b00, we: 2'b00, a0: 8'h0, a1: 8'h0, d0: 16'h0, d1: 16'h0};
        cycle(cur, g);
        cur = '{rst: 1'b0, req: 2'b11, lock: 2'b01, we: 2'b00, a0: 8'h40, a1: 8'h41, d0: 16'h0, d1: 16'h0};
        for (int i = 0; i < 12; i++) begin
            cycle(cur, g);
            chk($sformatf("lock_seq%0d_p1_gnt", i), bus.p1_gnt, TO ? (i == 8) : 1'b0);
            chk($sformatf("lock_seq%0d_p0_gnt", i), bus.p0_gnt, TO ? (i != 8) : 1'b1);
        end

        // Random traffic; each requester holds its request until granted.
        hold = 2'b00;
        for (int n = 0; n < 600; n++) begin
            cur.rst = ($urandom_range(0, 63) == 0);
            if (!hold[0]) begin
                cur.req[0] = ($urandom_range(0, 2) != 0);
                cur.we[0]  = 1'($urandom_range(0, 1));
                cur.a0     = 8'($urandom_range(0, 15));
                cur.d0     = 16'($urandom);
            end
            if (!hold[1]) begin
                cur.req[1] = ($urandom_range(0, 2) != 0);
                cur.we[1]  = 1'($urandom_range(0, 1));
                cur.a1     = 8'($urandom_range(0, 15));
                cur.d1     = 16'($urandom);
            end
            cur.lock[0] = ($urandom_range(0, 2) != 0);
            cur.lock[1] = ($urandom_range(0, 3) == 0);
            cycle(cur, g);
            hold[0] = cur.req[0] && (g != 0);
            hold[1] = cur.req[1] && (g != 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
